// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the I/D memory port arbiter: AHB transfer/size codes
// and the data-phase owner encoding.
package mem_port_arbiter_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_I    = 2'b01,
      OWN_D    = 2'b10
   } owner_e;

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of D address phases granted while I is waiting;
// force_i_out tells the arbiter the next grant must go to I.
module arb_streak_ctr #(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req_in,
   input  logic d_acc_in,
   input  logic i_acc_in,
   output logic force_i_out
);

   localparam int unsigned CW = $clog2(MAX_D_STREAK + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_D_STREAK);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!i_req_in || i_acc_in) begin
         cnt_d = '0;
      end else if (d_acc_in && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_i_out = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one AHB-lite master port between instruction fetch (I) and
// load/store (D), pipelining address phases and routing completions.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = 4,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              msriscv32_mp_clk_in,
   input  logic              msriscv32_mp_rst_in,
   input  logic              i_req_in,
   input  logic [ADDR_W-1:0] i_addr_in,
   output logic [31:0]       i_rdata_out,
   output logic              i_ready_out,
   output logic              i_err_out,
   input  logic              d_req_in,
   input  logic              d_wr_in,
   input  logic [ADDR_W-1:0] d_addr_in,
   input  logic [1:0]        d_size_in,
   input  logic [31:0]       d_wdata_in,
   output logic [31:0]       d_rdata_out,
   output logic              d_ready_out,
   output logic              d_err_out,
   output logic [ADDR_W-1:0] haddr_out,
   output logic [1:0]        htrans_out,
   output logic              hwrite_out,
   output logic [2:0]        hsize_out,
   output logic [31:0]       hwdata_out,
   input  logic [31:0]       hrdata_in,
   input  logic              hready_in,
   input  logic              hresp_in
);

   owner_e      dp_owner_q, dp_owner_d;
   owner_e      ap_owner_q, ap_owner_d;
   owner_e      grant, ap_owner;
   logic        ap_hold_q, ap_hold_d;
   logic [31:0] wdata_q, wdata_d;
   logic        i_elig, d_elig, err_phase, i_acc, d_acc, force_i;

   arb_streak_ctr #(
      .MAX_D_STREAK(MAX_D_STREAK)
   ) u_streak (
      .clk        (msriscv32_mp_clk_in),
      .rst        (msriscv32_mp_rst_in),
      .i_req_in   (i_req_in),
      .d_acc_in   (d_acc),
      .i_acc_in   (i_acc),
      .force_i_out(force_i)
   );

   always_comb begin
      i_elig = i_req_in && (dp_owner_q != OWN_I);
      d_elig = d_req_in && (dp_owner_q != OWN_D);
      if (d_elig && !(i_elig && force_i)) begin
         grant = OWN_D;
      end else if (i_elig) begin
         grant = OWN_I;
      end else begin
         grant = OWN_NONE;
      end
      // Both error cycles idle the bus; this also drops any held address phase.
      err_phase  = hresp_in && (dp_owner_q != OWN_NONE);
      ap_owner   = err_phase ? OWN_NONE : (ap_hold_q ? ap_owner_q : grant);
      i_acc      = hready_in && (ap_owner == OWN_I);
      d_acc      = hready_in && (ap_owner == OWN_D);
      dp_owner_d = hready_in ? ap_owner : dp_owner_q;
      ap_hold_d  = !hready_in && (ap_owner != OWN_NONE);
      ap_owner_d = ap_owner;
      wdata_d    = (d_acc && d_wr_in) ? d_wdata_in : wdata_q;
   end

   always_ff @(posedge msriscv32_mp_clk_in) begin
      if (msriscv32_mp_rst_in) begin
         dp_owner_q <= OWN_NONE;
         ap_owner_q <= OWN_NONE;
         ap_hold_q  <= 1'b0;
         wdata_q    <= '0;
      end else begin
         dp_owner_q <= dp_owner_d;
         ap_owner_q <= ap_owner_d;
         ap_hold_q  <= ap_hold_d;
         wdata_q    <= wdata_d;
      end
   end

   always_comb begin
      htrans_out  = HTRANS_IDLE;
      haddr_out   = '0;
      hwrite_out  = 1'b0;
      hsize_out   = HSIZE_WORD;
      hwdata_out  = '0;
      i_ready_out = 1'b0;
      i_err_out   = 1'b0;
      i_rdata_out = '0;
      d_ready_out = 1'b0;
      d_err_out   = 1'b0;
      d_rdata_out = '0;
      if (!msriscv32_mp_rst_in) begin
         case (ap_owner)
            OWN_I: begin
               htrans_out = HTRANS_NONSEQ;
               haddr_out  = i_addr_in;
            end
            OWN_D: begin
               htrans_out = HTRANS_NONSEQ;
               haddr_out  = d_addr_in;
               hwrite_out = d_wr_in;
               hsize_out  = {1'b0, d_size_in};
            end
            default: ;
         endcase
         if (dp_owner_q == OWN_D) begin
            hwdata_out = wdata_q;
         end
         i_ready_out = hready_in && (dp_owner_q == OWN_I);
         d_ready_out = hready_in && (dp_owner_q == OWN_D);
         i_err_out   = i_ready_out && hresp_in;
         d_err_out   = d_ready_out && hresp_in;
         i_rdata_out = i_ready_out ? hrdata_in : '0;
         d_rdata_out = d_ready_out ? hrdata_in : '0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table followed by
// wait-state, bus-error and D-streak sequences.
module tb_mem_port_arbiter;

   typedef struct {
      logic        rst;
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_wr;
      logic [31:0] d_addr;
      logic [1:0]  d_size;
      logic [31:0] d_wdata;
      logic [31:0] hrdata;
      logic        hready;
      logic        hresp;
   } in_t;

   typedef struct {
      logic [1:0]  htrans;
      logic [31:0] haddr;
      logic        hwrite;
      logic [2:0]  hsize;
      logic [31:0] hwdata;
      logic        i_ready;
      logic [31:0] i_rdata;
      logic        i_err;
      logic        d_ready;
      logic [31:0] d_rdata;
      logic        d_err;
   } out_t;

   typedef struct {
      in_t  vi;
      out_t vo;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        i_err;
   logic        d_req;
   logic        d_wr;
   logic [31:0] d_addr;
   logic [1:0]  d_size;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        d_err;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(
      .MAX_D_STREAK(4),
      .ADDR_W      (32)
   ) dut (
      .msriscv32_mp_clk_in(clk),
      .msriscv32_mp_rst_in(rst),
      .i_req_in           (i_req),
      .i_addr_in          (i_addr),
      .i_rdata_out        (i_rdata),
      .i_ready_out        (i_ready),
      .i_err_out          (i_err),
      .d_req_in           (d_req),
      .d_wr_in            (d_wr),
      .d_addr_in          (d_addr),
      .d_size_in          (d_size),
      .d_wdata_in         (d_wdata),
      .d_rdata_out        (d_rdata),
      .d_ready_out        (d_ready),
      .d_err_out          (d_err),
      .haddr_out          (haddr),
      .htrans_out         (htrans),
      .hwrite_out         (hwrite),
      .hsize_out          (hsize),
      .hwdata_out         (hwdata),
      .hrdata_in          (hrdata),
      .hready_in          (hready),
      .hresp_in           (hresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic in_t mk_in(logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
                                 logic [31:0] da, logic [1:0] ds, logic [31:0] dwd,
                                 logic [31:0] hrd, logic hrdy, logic hrsp);
      in_t v;
      v.rst = r; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_wr = dw;
      v.d_addr = da; v.d_size = ds; v.d_wdata = dwd; v.hrdata = hrd;
      v.hready = hrdy; v.hresp = hrsp;
      return v;
   endfunction

   function automatic out_t mk_out(logic [1:0] ht, logic [31:0] ha, logic hw, logic [2:0] hs,
                                   logic [31:0] hwd, logic ir, logic [31:0] ird, logic ie,
                                   logic dr, logic [31:0] drd, logic de);
      out_t v;
      v.htrans = ht; v.haddr = ha; v.hwrite = hw; v.hsize = hs; v.hwdata = hwd;
      v.i_ready = ir; v.i_rdata = ird; v.i_err = ie;
      v.d_ready = dr; v.d_rdata = drd; v.d_err = de;
      return v;
   endfunction

   function automatic in_t idle_in();
      return mk_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0, 32'h0, 1'b1, 1'b0);
   endfunction

   task automatic apply(input in_t v);
      rst = v.rst; i_req = v.i_req; i_addr = v.i_addr;
      d_req = v.d_req; d_wr = v.d_wr; d_addr = v.d_addr; d_size = v.d_size;
      d_wdata = v.d_wdata; hrdata = v.hrdata; hready = v.hready; hresp = v.hresp;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input out_t e);
      chk({tag, " htrans"},  32'(htrans),  32'(e.htrans));
      chk({tag, " haddr"},   haddr,        e.haddr);
      chk({tag, " hwrite"},  32'(hwrite),  32'(e.hwrite));
      chk({tag, " hsize"},   32'(hsize),   32'(e.hsize));
      chk({tag, " hwdata"},  hwdata,       e.hwdata);
      chk({tag, " i_ready"}, 32'(i_ready), 32'(e.i_ready));
      chk({tag, " i_rdata"}, i_rdata,      e.i_rdata);
      chk({tag, " i_err"},   32'(i_err),   32'(e.i_err));
      chk({tag, " d_ready"}, 32'(d_ready), 32'(e.d_ready));
      chk({tag, " d_rdata"}, d_rdata,      e.d_rdata);
      chk({tag, " d_err"},   32'(d_err),   32'(e.d_err));
   endtask

   vec_t tbl[15];
   in_t  cur;

   initial begin
      // Reset with both requesting, then alternating D/I, a store, and reset mid-transfer
      for (int k = 0; k < 3; k++) begin
         tbl[k].vi = mk_in(1, 1, 32'h1000, 1, 0, 32'h200, 2'b10, 32'h0, 32'h0, 1, 0);
         tbl[k].vo = mk_out(2'b00, 32'h0, 0, 3'b010, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
      end
      tbl[3].vi  = mk_in(0, 1, 32'h1000, 1, 0, 32'h200, 2'b10, 32'h0, 32'h11111111, 1, 0);
      tbl[3].vo  = mk_out(2'b10, 32'h200, 0, 3'b010, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
      tbl[4].vi  = mk_in(0, 1, 32'h1000, 1, 0, 32'h200, 2'b10, 32'h0, 32'hAAAA0001, 1, 0);
      tbl[4].vo  = mk_out(2'b10, 32'h1000, 0, 3'b010, 32'h0, 0, 32'h0, 0, 1, 32'hAAAA0001, 0);
      tbl[5].vi  = mk_in(0, 1, 32'h1004, 1, 0, 32'h204, 2'b10, 32'h0, 32'hBBBB0002, 1, 0);
      tbl[5].vo  = mk_out(2'b10, 32'h204, 0, 3'b010, 32'h0, 1, 32'hBBBB0002, 0, 0, 32'h0, 0);
      tbl[6].vi  = mk_in(0, 1, 32'h1004, 1, 0, 32'h204, 2'b10, 32'h0, 32'hCCCC0003, 1, 0);
      tbl[6].vo  = mk_out(2'b10, 32'h1004, 0, 3'b010, 32'h0, 0, 32'h0, 0, 1, 32'hCCCC0003, 0);
      tbl[7].vi  = mk_in(0, 0, 32'h0, 0, 0, 32'h0, 2'b10, 32'h0, 32'hDDDD0004, 1, 0);
      tbl[7].vo  = mk_out(2'b00, 32'h0, 0, 3'b010, 32'h0, 1, 32'hDDDD0004, 0, 0, 32'h0, 0);
      tbl[8].vi  = mk_in(0, 0, 32'h0, 0, 0, 32'h0, 2'b10, 32'h0, 32'hEEEE0005, 1, 0);
      tbl[8].vo  = mk_out(2'b00, 32'h0, 0, 3'b010, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
      tbl[9].vi  = mk_in(0, 0, 32'h0, 1, 1, 32'h104, 2'b01, 32'hABCD1234, 32'h0, 1, 0);
      tbl[9].vo  = mk_out(2'b10, 32'h104, 1, 3'b001, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
      tbl[10].vi = mk_in(0, 0, 32'h0, 0, 0, 32'h0, 2'b10, 32'h0, 32'h55555555, 1, 0);
      tbl[10].vo = mk_out(2'b00, 32'h0, 0, 3'b010, 32'hABCD1234, 0, 32'h0, 0, 1, 32'h55555555, 0);
      tbl[11].vi = mk_in(0, 0, 32'h0, 0, 0, 32'h0, 2'b10, 32'h0, 32'h0, 1, 0);
      tbl[11].vo = mk_out(2'b00, 32'h0, 0, 3'b010, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
      tbl[12].vi = mk_in(0, 0, 32'h0, 1, 0, 32'h300, 2'b10, 32'h0, 32'h0, 1, 0);
      tbl[12].vo = mk_out(2'b10, 32'h300, 0, 3'b010, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
      tbl[13].vi = mk_in(1, 0, 32'h0, 1, 0, 32'h300, 2'b10, 32'h0, 32'h77777777, 1, 0);
      tbl[13].vo = mk_out(2'b00, 32'h0, 0, 3'b010, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
      tbl[14].vi = mk_in(0, 0, 32'h0, 0, 0, 32'h0, 2'b10, 32'h0, 32'h77777777, 1, 0);
      tbl[14].vo = mk_out(2'b00, 32'h0, 0, 3'b010, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);

      apply(tbl[0].vi);
      @(negedge clk);
      for (int k = 0; k < 15; k++) begin
         apply(tbl[k].vi);
         #1;
         check_all($sformatf("v%0d", k), tbl[k].vo);
         step();
      end

      // Two wait states in an I data phase while D arrives: D address is held
      cur = idle_in(); cur.i_req = 1; cur.i_addr = 32'h2000;
      apply(cur); #1;
      chk("hold0 htrans", 32'(htrans), 32'h2);
      chk("hold0 haddr", haddr, 32'h2000);
      step();
      cur.hready = 0; cur.d_req = 1; cur.d_addr = 32'h400;
      for (int k = 0; k < 2; k++) begin
         apply(cur); #1;
         chk($sformatf("hold%0d htrans", k + 1), 32'(htrans), 32'h2);
         chk($sformatf("hold%0d haddr", k + 1), haddr, 32'h400);
         chk($sformatf("hold%0d i_ready", k + 1), 32'(i_ready), 32'h0);
         step();
      end
      cur.hready = 1; cur.hrdata = 32'h12345678;
      apply(cur); #1;
      chk("hold3 i_ready", 32'(i_ready), 32'h1);
      chk("hold3 i_rdata", i_rdata, 32'h12345678);
      chk("hold3 haddr", haddr, 32'h400);
      chk("hold3 d_ready", 32'(d_ready), 32'h0);
      step();
      cur.i_req = 0; cur.hrdata = 32'h0BAD0009;
      apply(cur); #1;
      chk("hold4 d_ready", 32'(d_ready), 32'h1);
      chk("hold4 d_rdata", d_rdata, 32'h0BAD0009);
      chk("hold4 htrans", 32'(htrans), 32'h0);
      step();

      // Two-cycle error response on a D data phase
      cur = idle_in(); cur.d_req = 1; cur.d_addr = 32'h500;
      apply(cur); #1;
      chk("err0 htrans", 32'(htrans), 32'h2);
      step();
      cur.i_req = 1; cur.i_addr = 32'h3000; cur.hready = 0; cur.hresp = 1;
      apply(cur); #1;
      chk("err1 htrans", 32'(htrans), 32'h0);
      chk("err1 d_ready", 32'(d_ready), 32'h0);
      chk("err1 i_err", 32'(i_err), 32'h0);
      step();
      cur.hready = 1;
      apply(cur); #1;
      chk("err2 d_ready", 32'(d_ready), 32'h1);
      chk("err2 d_err", 32'(d_err), 32'h1);
      chk("err2 i_ready", 32'(i_ready), 32'h0);
      chk("err2 i_err", 32'(i_err), 32'h0);
      chk("err2 htrans", 32'(htrans), 32'h0);
      step();
      cur.hresp = 0; cur.d_req = 0;
      apply(cur); #1;
      chk("err3 htrans", 32'(htrans), 32'h2);
      chk("err3 haddr", haddr, 32'h3000);
      step();
      cur.i_req = 0;
      apply(cur); #1;
      chk("err4 i_ready", 32'(i_ready), 32'h1);
      chk("err4 i_err", 32'(i_err), 32'h0);
      step();
      apply(idle_in());
      step();

      // Four errored D grants while I waits; the fifth grant is forced to I
      cur = idle_in(); cur.i_req = 1; cur.i_addr = 32'h7000; cur.d_req = 1; cur.d_addr = 32'h600;
      for (int k = 0; k < 4; k++) begin
         cur.hready = 1; cur.hresp = 0;
         apply(cur); #1;
         chk($sformatf("streak%0d grant_d", k), haddr, 32'h600);
         step();
         cur.hready = 0; cur.hresp = 1;
         apply(cur); #1;
         chk($sformatf("streak%0d idle", k), 32'(htrans), 32'h0);
         step();
         cur.hready = 1;
         apply(cur); #1;
         chk($sformatf("streak%0d d_err", k), 32'(d_err), 32'h1);
         step();
      end
      cur.hresp = 0;
      apply(cur); #1;
      chk("streak forced htrans", 32'(htrans), 32'h2);
      chk("streak forced grant_i", haddr, 32'h7000);
      step();
      apply(cur); #1;
      chk("streak after i_ready", 32'(i_ready), 32'h1);
      chk("streak after grant_d", haddr, 32'h600);
      step();
      cur.i_req = 0;
      apply(cur); #1;
      chk("streak final d_ready", 32'(d_ready), 32'h1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
